// File: rtl/psum_accum_array.sv
// Lane-parallel partial-sum accumulator: sums K product beats plus a per-lane bias and
// emits one saturated Z vector per burst. Output is 1 cycle after the last beat; input stalls while Z is held unaccepted.
`timescale 1ns/1ps
module psum_accum_array #(
  parameter int dataWidth   = 32,
  parameter int pactivation = 16,
  parameter int cntWidth    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [dataWidth*pactivation-1:0] bias,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [dataWidth*pactivation-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [dataWidth*pactivation-1:0] out_data,
  output logic [cntWidth-1:0]              beat_count,
  output logic                             sat_flag
);

  localparam int vecWidth = dataWidth * pactivation;
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [dataWidth-1:0] laneMax = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] laneMin = {1'b1, {(dataWidth-1){1'b0}}};
  localparam logic [cntWidth-1:0]  cntOne  = {{(cntWidth-1){1'b0}}, 1'b1};

  logic [0:0]             state;
  logic                   first;
  logic [vecWidth-1:0]    acc;
  logic [vecWidth-1:0]    accNext;
  logic [cntWidth-1:0]    cnt;
  logic [cntWidth-1:0]    cntNext;
  logic                   satSticky;
  logic                   satNext;
  logic [pactivation-1:0] laneSat;
  logic                   cntSat;
  logic                   accept;

  // One extra sum bit per lane; disagreement of the top two bits marks overflow.
  for (genvar i = 0; i < pactivation; i++) begin : gLane
    logic [dataWidth-1:0] base;
    logic [dataWidth-1:0] addend;
    logic [dataWidth:0]   sum;

    assign base   = first ? bias[i*dataWidth +: dataWidth] : acc[i*dataWidth +: dataWidth];
    assign addend = in_data[i*dataWidth +: dataWidth];
    assign sum    = {base[dataWidth-1], base} + {addend[dataWidth-1], addend};
    assign laneSat[i] = sum[dataWidth] ^ sum[dataWidth-1];
    assign accNext[i*dataWidth +: dataWidth] =
      !laneSat[i] ? sum[dataWidth-1:0] : (sum[dataWidth] ? laneMin : laneMax);
  end

  // The beat counter sticks at all-ones rather than wrapping, and flags it as saturation.
  assign cntSat  = !first && (&cnt);
  assign cntNext = first ? cntOne : (cntSat ? cnt : cnt + cntOne);
  assign satNext = (!first && satSticky) || (|laneSat) || cntSat;

  assign in_ready = !rst && ((state == ACCUM) || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      first      <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
      satSticky  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
      sat_flag   <= 1'b0;
    end else if (accept) begin
      acc       <= accNext;
      cnt       <= cntNext;
      satSticky <= satNext;
      first     <= in_last;
      if (in_last) begin
        out_data   <= accNext;
        beat_count <= cntNext;
        sat_flag   <= satNext;
        out_valid  <= 1'b1;
        state      <= HOLD;
      end else begin
        // An accepted beat in HOLD implies out_ready, so the held vector is consumed here.
        out_valid <= 1'b0;
        state     <= ACCUM;
      end
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
      state     <= ACCUM;
    end
  end

endmodule

// File: tb/tb_psum_accum_array.sv
// Bench for psum_accum_array: scoreboard of expected Z vectors plus a vector table
// and hand-written sequences for latency, backpressure, back-to-back and reset cases.
`timescale 1ns/1ps
module tb_psum_accum_array;

  localparam int DW = 32;
  localparam int NL = 16;
  localparam int CW = 16;
  localparam int VW = DW * NL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] bias = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_data;
  logic [CW-1:0] beat_count;
  logic          sat_flag;

  always #5 clk = ~clk;

  psum_accum_array #(.dataWidth(DW), .pactivation(NL), .cntWidth(CW)) dut (
    .clk(clk), .rst(rst), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count), .sat_flag(sat_flag)
  );

  typedef struct {
    logic [VW-1:0] data;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  typedef struct {
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    int            k;
    logic [DW-1:0] expv;
    logic          es;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [VW-1:0] repl(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic [VW-1:0] d, input logic [CW-1:0] c, input logic s);
    exp_t e;
    e.data = d; e.cnt = c; e.sat = s;
    sbq.push_back(e);
  endtask

  // Inputs are stable from negedge to the next posedge, so a handshake seen here is the real one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("z_data", out_data, e.data);
        chk("z_beat_count", VW'(beat_count), VW'(e.cnt));
        chk("z_sat_flag", VW'(sat_flag), VW'(e.sat));
      end
    end
  end

  task automatic sendBeat(input logic [VW-1:0] d, input logic [VW-1:0] b, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; bias = b; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout actual=in_ready_0 required=in_ready_1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic sendBurst(input logic [VW-1:0] d, input logic [VW-1:0] b, input int k);
    for (int i = 0; i < k; i++) sendBeat(d, b, i == k - 1);
  endtask

  initial begin
    logic [VW-1:0] b3, d3, e3;
    int n;

    tbl[0] = '{32'd0,        32'd3,        2, 32'd6,        1'b0};
    tbl[1] = '{32'd10,       32'd1,        4, 32'd14,       1'b0};
    tbl[2] = '{32'hFFFFFF9C, 32'd7,        3, 32'hFFFFFFB1, 1'b0};
    tbl[3] = '{32'h7FFFFFF0, 32'd8,        3, 32'h7FFFFFFF, 1'b1};
    tbl[4] = '{32'h80000005, 32'hFFFFFFFC, 2, 32'h80000000, 1'b1};
    tbl[5] = '{32'd0,        32'd5,        1, 32'd5,        1'b0};
    tbl[6] = '{32'd100,      32'd0,        1, 32'd100,      1'b0};

    // Reset released between clock edges.
    #23 rst = 1'b0;
    #1;
    chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
    chk("rst_out_data", out_data, '0);
    chk("rst_beat_count", VW'(beat_count), '0);
    chk("rst_sat_flag", VW'(sat_flag), VW'(1'b0));
    chk("rst_in_ready", VW'(in_ready), VW'(1'b1));
    @(posedge clk); #1;

    // K=4 burst: one-cycle latency and a one-cycle pulse.
    pushExp(repl(32'd14), 16'd4, 1'b0);
    sendBurst(repl(32'd1), repl(32'd10), 4);
    @(negedge clk);
    chk("t2_latency", VW'(out_valid), VW'(1'b1));
    @(negedge clk);
    chk("t2_pulse", VW'(out_valid), VW'(1'b0));
    @(posedge clk); #1;

    // Mixed-lane saturation; the following table entry must clear sat_flag.
    b3 = '0; d3 = repl(32'd1); e3 = repl(32'd2);
    b3[3*DW +: DW] = 32'h7FFFFFF0; d3[3*DW +: DW] = 32'h20; e3[3*DW +: DW] = 32'h7FFFFFFF;
    d3[15*DW +: DW] = 32'hFFFFFFFB; e3[15*DW +: DW] = 32'hFFFFFFF6;
    pushExp(e3, 16'd2, 1'b1);
    sendBurst(d3, b3, 2);

    for (int i = 0; i < 7; i++) begin
      pushExp(repl(tbl[i].expv), CW'(tbl[i].k), tbl[i].es);
      sendBurst(repl(tbl[i].d), repl(tbl[i].b), tbl[i].k);
    end
    @(posedge clk); #1;

    // Backpressure: a pending beat must wait while Z is held, then count exactly once.
    out_ready = 1'b0;
    pushExp(repl(32'd6), 16'd2, 1'b0);
    sendBurst(repl(32'd3), repl(32'd0), 2);
    in_valid = 1'b1; in_data = repl(32'd2); bias = repl(32'd1); in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", VW'(in_ready), VW'(1'b0));
      chk("t4_out_valid", VW'(out_valid), VW'(1'b1));
      chk("t4_out_data", out_data, repl(32'd6));
    end
    @(posedge clk); #1;
    pushExp(repl(32'd5), 16'd2, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    sendBeat(repl(32'd2), repl(32'd1), 1'b1);
    @(posedge clk); #1;

    // Reset while holding Z clears outputs without waiting for a clock edge.
    out_ready = 1'b0;
    sendBurst(repl(32'd1), repl(32'd0), 1);
    @(negedge clk);
    chk("hold_before_rst", VW'(out_valid), VW'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", VW'(out_valid), VW'(1'b0));
    chk("async_rst_out_data", out_data, '0);
    chk("async_rst_beat_count", VW'(beat_count), '0);
    #0.5 rst = 1'b0;
    #0.5;
    chk("async_rst_in_ready", VW'(in_ready), VW'(1'b1));
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-burst discards the partial sum.
    sendBeat(repl(32'd9), repl(32'd100), 1'b0);
    sendBeat(repl(32'd9), repl(32'd100), 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    pushExp(repl(32'd6), 16'd2, 1'b0);
    sendBurst(repl(32'd3), repl(32'd0), 2);
    @(posedge clk); #1;

    // Back-to-back single-beat bursts.
    for (int i = 0; i < 8; i++) pushExp(repl(DW'(i)), 16'd1, 1'b0);
    in_valid = 1'b1; in_last = 1'b1; bias = '0;
    for (int i = 0; i < 8; i++) begin
      in_data = repl(DW'(i));
      @(negedge clk);
      if (i > 0) chk("t5_continuous", VW'(out_valid), VW'(1'b1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
